conv2x2_stream_ctrl: RTL and testbench
======================================

// Module: conv2x2_stream_ctrl
// PURPOSE
//  Sequencer for the 2x2 convolution datapath (line buffers + kernal_2by2). Accepts a kernel-weight
//  config, then one IMG_HEIGHT x IMG_WIDTH frame of raster pixels. Drives the datapath one pixel per
//  clock, tags datapath results that belong to legal 2x2 windows (no row-wrap, no pre-fill junk),
//  and emits only those with frame framing. Sits between the pixel source/host and the conv datapath.
// PARAMETERS
//  DATA_W      8   pixel/weight width
//  IMG_WIDTH   4   pixels per row (>=2)
//  IMG_HEIGHT  4   rows per frame (>=2)
//  CONV_LAT    2   clocks from pixel driven on dp_pixel to its window result on dp_result
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          async reset, active-high
//  start        in   1          frame request; sampled in IDLE only
//  kcfg_valid   in   1          weight config valid
//  kcfg_ready   out  1          high in LOAD_K only
//  kcfg_w       in   4*DATA_W   {w4,w3,w2,w1}
//  s_valid      in   1          pixel source valid
//  s_ready      out  1          high in STREAM only
//  s_data       in   DATA_W     raster pixel
//  dp_clr       out  1          datapath synchronous clear (OR'd into datapath reset)
//  dp_kload     out  1          datapath kernel_load_valid
//  dp_w         out  4*DATA_W   registered weights to datapath
//  dp_pixel     out  DATA_W     pixel to datapath
//  dp_result    in   2*DATA_W+5 datapath result
//  m_valid      out  1          legal window result valid (no backpressure)
//  m_data       out  2*DATA_W+5 result
//  m_last       out  1          with final legal window of frame
//  busy         out  1          state != IDLE
//  frame_done   out  1          1-cycle pulse on DONE
//  err_gap      out  1          sticky: s_valid low during STREAM; cleared by start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters, tag pipe, weights cleared.
//  FSM: IDLE -start-> LOAD_K -(kcfg_valid&kcfg_ready)-> STREAM -(last pixel accepted)-> DRAIN
//       -(CONV_LAT cycles)-> DONE -(1 cycle)-> IDLE.
//  LOAD_K: dp_clr=1 every cycle in state; on handshake latch kcfg_w into dp_w, dp_kload=1 that cycle.
//  STREAM: s_ready=1; datapath shifts every clock and cannot stall, so on s_valid=0 dp_pixel=0,
//   err_gap<=1, and the position counters STILL advance (frame geometry preserved). dp_pixel is
//   s_data when s_valid, registered? no: combinational pass-through, dp latency is CONV_LAT.
//  Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1; col wraps to 0 and row increments at
//   col==IMG_WIDTH-1. Last pixel = (row==H-1 && col==W-1); transition to DRAIN same edge.
//  Legal tag for pixel at (row,col): row>=1 && col>=1 (window bottom-right). Tag and is_last
//   (row==H-1&&col==W-1) enter a CONV_LAT-deep shift pipe; pipe output gates m_valid,
//   m_data=dp_result, m_last. Expect exactly (H-1)*(W-1) m_valid pulses per frame.
//  Pipe shifts zeros in outside STREAM; DRAIN exists solely to flush it.
//  start while busy: ignored. kcfg_valid outside LOAD_K: ignored (kcfg_ready=0).
//  Reset mid-frame: immediate return to IDLE, pipe flushed, no m_valid/m_last afterwards.
//  Widths: col/row counters $clog2(IMG_WIDTH)/$clog2(IMG_HEIGHT), min 1 bit; no arithmetic on data.
// STRUCTURE
//  Shared package conv_pkg: state encoding (IDLE,LOAD_K,STREAM,DRAIN,DONE), RES_W=2*DATA_W+5.
//  One sub-module: conv_tag_pipe (parameterised DEPTH=CONV_LAT, WIDTH=2 shift register with clear).
//  Datapath itself is instantiated by the parent, not inside this block.
// TESTING
//  H=W=4, CONV_LAT=2, weights {1,1,1,1}, pixels 1..16 gapless -> 9 m_valid, data 14,18,22,30,34,38,
//   46,50,54, m_last on 9th only, frame_done 2 cycles after pixel 16.
//  kcfg_valid held low 5 cycles in LOAD_K -> s_ready stays 0, dp_clr high throughout, no m_valid.
//  s_valid dropped for pixel 6 -> err_gap=1 sticky, still 9 outputs, windows using pixel 6 see 0.
//  start pulsed during STREAM -> ignored, frame completes normally; next start clears err_gap.
//  rst asserted after pixel 10 -> all outputs 0 next cycle, no m_last; fresh frame then passes test 1.
//  Back-to-back frames (start in cycle after frame_done) -> second frame bit-exact, dp_clr seen between.

Source files
------------

// File: rtl/conv2x2_stream_ctrl_pkg.sv
// Shared definitions for the 2x2 convolution stream sequencer.
//   state_t : sequencer states
//   res_w() : width of a datapath window result for a given pixel width
//   cnt_w() : counter width for a modulus n, never below one bit
package conv2x2_stream_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_K,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int unsigned DATA_W_DEF = 8;

   function automatic int unsigned res_w(input int unsigned dw);
      return 2 * dw + 5;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv2x2_stream_ctrl_if.sv
// Bus bundle between the sequencer and its neighbours (host, pixel source,
// convolution datapath, result sink).
//   slave  : the sequencer's view
//   master : the surrounding system's view (host/source/datapath/sink)
// Signals:
//   start                     frame request
//   kcfg_valid/ready, kcfg_w  kernel weight config {w4,w3,w2,w1}
//   s_valid/ready, s_data     raster pixel stream
//   dp_clr, dp_kload, dp_w,   datapath control, weights and pixel
//   dp_pixel, dp_result       datapath window result
//   m_valid, m_data, m_last   legal-window results with frame framing
//   busy, frame_done, err_gap status
interface conv2x2_stream_ctrl_if
   import conv2x2_stream_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
);
   localparam int unsigned RES_W = res_w(DATA_W);

   logic                  start;
   logic                  kcfg_valid;
   logic                  kcfg_ready;
   logic [4*DATA_W-1:0]   kcfg_w;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_W-1:0]     s_data;
   logic                  dp_clr;
   logic                  dp_kload;
   logic [4*DATA_W-1:0]   dp_w;
   logic [DATA_W-1:0]     dp_pixel;
   logic [RES_W-1:0]      dp_result;
   logic                  m_valid;
   logic [RES_W-1:0]      m_data;
   logic                  m_last;
   logic                  busy;
   logic                  frame_done;
   logic                  err_gap;

   modport slave (
      input  start, kcfg_valid, kcfg_w, s_valid, s_data, dp_result,
      output kcfg_ready, s_ready, dp_clr, dp_kload, dp_w, dp_pixel,
             m_valid, m_data, m_last, busy, frame_done, err_gap
   );

   modport master (
      output start, kcfg_valid, kcfg_w, s_valid, s_data, dp_result,
      input  kcfg_ready, s_ready, dp_clr, dp_kload, dp_w, dp_pixel,
             m_valid, m_data, m_last, busy, frame_done, err_gap
   );

endinterface

// File: rtl/conv2x2_stream_ctrl_tag_pipe.sv
// Fixed-latency shift register carrying per-pixel window tags alongside the
// convolution datapath so each tag emerges together with its result.
//   clk, rst : clock, async active-high reset
//   clr_i    : synchronous clear of every stage
//   d_i      : tag entering this cycle
//   q_o      : tag from DEPTH cycles earlier
module conv2x2_stream_ctrl_tag_pipe #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q <= '0;
      end else if (clr_i) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv2x2_stream_ctrl.sv
// Sequencer for the 2x2 convolution datapath. Takes a kernel-weight config,
// then streams one IMG_HEIGHT x IMG_WIDTH raster frame into the datapath one
// pixel per clock, and forwards only the datapath results that belong to
// complete 2x2 windows (no row wrap, no line-buffer pre-fill), marking the
// final one with m_last.
//   clk  : clock, rising edge
//   rst  : async reset, active-high
//   bus  : slave side of conv2x2_stream_ctrl_if (host config, pixel stream,
//          datapath control/result, result stream, status)
module conv2x2_stream_ctrl
   import conv2x2_stream_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned IMG_WIDTH  = 4,
   parameter int unsigned IMG_HEIGHT = 4,
   parameter int unsigned CONV_LAT   = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   conv2x2_stream_ctrl_if.slave        bus
);

   localparam int unsigned COL_W   = cnt_w(IMG_WIDTH);
   localparam int unsigned ROW_W   = cnt_w(IMG_HEIGHT);
   localparam int unsigned DRAIN_W = cnt_w(CONV_LAT);

   state_t               state_q;
   logic [COL_W-1:0]     col_q, col_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [DRAIN_W-1:0]   drain_q;
   logic                 kcfg_ready_q;
   logic                 s_ready_q;
   logic                 dp_clr_q;
   logic                 dp_kload_q;
   logic [4*DATA_W-1:0]  dp_w_q;
   logic                 busy_q;
   logic                 frame_done_q;
   logic                 err_gap_q;

   logic                 col_wrap, last_row, last_pix, legal;
   logic [1:0]           tag_in, tag_out;

   // Raster position bookkeeping for the pixel being driven this cycle.
   always_comb begin
      col_wrap = (col_q == COL_W'(IMG_WIDTH - 1));
      last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
      last_pix = col_wrap && last_row;
      // Pixel is the bottom-right corner of a fully populated window.
      legal    = (row_q != '0) && (col_q != '0);
      col_d    = col_wrap ? '0 : col_q + 1'b1;
      row_d    = row_q;
      if (col_wrap) begin
         row_d = last_row ? '0 : row_q + 1'b1;
      end
   end

   // Sequencer; every status/control output is registered alongside state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         drain_q      <= '0;
         kcfg_ready_q <= 1'b0;
         s_ready_q    <= 1'b0;
         dp_clr_q     <= 1'b0;
         dp_kload_q   <= 1'b0;
         dp_w_q       <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_gap_q    <= 1'b0;
      end else begin
         dp_kload_q   <= 1'b0;
         frame_done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q      <= ST_LOAD_K;
                  kcfg_ready_q <= 1'b1;
                  dp_clr_q     <= 1'b1;
                  busy_q       <= 1'b1;
                  err_gap_q    <= 1'b0;
               end
            end
            ST_LOAD_K: begin
               if (bus.kcfg_valid && kcfg_ready_q) begin
                  state_q      <= ST_STREAM;
                  kcfg_ready_q <= 1'b0;
                  dp_clr_q     <= 1'b0;
                  s_ready_q    <= 1'b1;
                  dp_w_q       <= bus.kcfg_w;
                  dp_kload_q   <= 1'b1;
                  col_q        <= '0;
                  row_q        <= '0;
               end
            end
            ST_STREAM: begin
               // The datapath cannot stall: a missing pixel still consumes
               // its raster slot so frame geometry is kept.
               col_q <= col_d;
               row_q <= row_d;
               if (!bus.s_valid) begin
                  err_gap_q <= 1'b1;
               end
               if (last_pix) begin
                  state_q   <= ST_DRAIN;
                  s_ready_q <= 1'b0;
                  drain_q   <= '0;
               end
            end
            ST_DRAIN: begin
               drain_q <= drain_q + 1'b1;
               if (drain_q == DRAIN_W'(CONV_LAT - 1)) begin
                  state_q      <= ST_DONE;
                  frame_done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Tags follow the pixel through the datapath latency; zeros outside STREAM
   // so pre-fill and post-frame results are never forwarded.
   assign tag_in = (state_q == ST_STREAM) ? {last_pix, legal} : 2'b00;

   conv2x2_stream_ctrl_tag_pipe #(
      .DEPTH (CONV_LAT),
      .WIDTH (2)
   ) u_tag_pipe (
      .clk   (clk),
      .rst   (rst),
      .clr_i (dp_clr_q),
      .d_i   (tag_in),
      .q_o   (tag_out)
   );

   assign bus.dp_pixel   = ((state_q == ST_STREAM) && bus.s_valid) ? bus.s_data : '0;
   assign bus.kcfg_ready = kcfg_ready_q;
   assign bus.s_ready    = s_ready_q;
   assign bus.dp_clr     = dp_clr_q;
   assign bus.dp_kload   = dp_kload_q;
   assign bus.dp_w       = dp_w_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.err_gap    = err_gap_q;
   assign bus.m_valid    = tag_out[0];
   assign bus.m_last     = tag_out[1] & tag_out[0];
   assign bus.m_data     = tag_out[0] ? bus.dp_result : '0;

endmodule

// File: tb/tb_conv2x2_stream_ctrl.sv
// Bench for conv2x2_stream_ctrl: a behavioural 2x2 line-buffer datapath
// (latency 2) closes the loop; expected window results are hand-computed
// constants pushed to a scoreboard and popped by an output monitor.
module tb_conv2x2_stream_ctrl;

   localparam int unsigned DW    = 8;
   localparam int unsigned W     = 4;
   localparam int unsigned H     = 4;
   localparam int unsigned RES_W = 2 * DW + 5;

   typedef struct packed {
      logic [RES_W-1:0] data;
      logic             last;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t sb[$];

   // Window sums for pixels 1..16, weights all 1 (bottom-right order).
   int exp_norm [9] = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
   // Same frame with pixel 6 replaced by 0.
   int exp_gap  [9] = '{8, 12, 22, 24, 28, 38, 46, 50, 54};

   conv2x2_stream_ctrl_if #(.DATA_W(DW)) bus ();

   conv2x2_stream_ctrl #(
      .DATA_W     (DW),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .CONV_LAT   (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural datapath: hist[0] newest pixel, hist[W+1] top-left of window.
   logic [DW-1:0]    hist [W+2];
   logic [4*DW-1:0]  w_m;
   logic [RES_W-1:0] sum_c, res_q;

   always_comb begin
      sum_c = RES_W'(w_m[DW-1:0])      * RES_W'(hist[W+1])
            + RES_W'(w_m[2*DW-1:DW])   * RES_W'(hist[W])
            + RES_W'(w_m[3*DW-1:2*DW]) * RES_W'(hist[1])
            + RES_W'(w_m[4*DW-1:3*DW]) * RES_W'(hist[0]);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < W + 2; i++) hist[i] <= '0;
         res_q <= '0;
         w_m   <= '0;
      end else if (bus.dp_clr) begin
         for (int i = 0; i < W + 2; i++) hist[i] <= '0;
         res_q <= '0;
      end else begin
         if (bus.dp_kload) w_m <= bus.dp_w;
         hist[0] <= bus.dp_pixel;
         for (int i = 1; i < W + 2; i++) hist[i] <= hist[i-1];
         res_q <= sum_c;
      end
   end

   assign bus.dp_result = res_q;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] outs();
      return {bus.busy, bus.kcfg_ready, bus.s_ready, bus.dp_clr, bus.dp_kload,
              bus.frame_done, bus.err_gap, bus.m_valid, bus.m_last,
              |bus.dp_w, |bus.dp_pixel, |bus.m_data};
   endfunction

   task automatic push_frame(input int sel, input int n, input bit with_last, input int mult);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.data = RES_W'(((sel == 0) ? exp_norm[i] : exp_gap[i]) * mult);
         e.last = with_last && (i == 8);
         sb.push_back(e);
      end
   endtask

   // Output monitor: pops one expectation per presented result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.m_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_valid", bus.m_valid, 0);
            end else begin
               e = sb.pop_front();
               chk("m_data", bus.m_data, e.data);
               chk("m_last", bus.m_last, e.last);
            end
         end else if (bus.m_last !== 1'b0) begin
            chk("m_last_without_valid", bus.m_last, 0);
         end
      end
   end

   task automatic run_frame(input int kdelay, input int gap_pix, input int start_pix,
                            input int abort_after, input logic [4*DW-1:0] wts);
      int gap;
      @(posedge clk); #1;
      chk("idle_busy", bus.busy, 0);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("ld_busy", bus.busy, 1);
      chk("ld_kready", bus.kcfg_ready, 1);
      chk("ld_clr", bus.dp_clr, 1);
      chk("ld_err_cleared", bus.err_gap, 0);
      chk("ld_sready", bus.s_ready, 0);
      for (int i = 0; i < kdelay; i++) begin
         @(posedge clk); #1;
         chk("ld_wait_sready", bus.s_ready, 0);
         chk("ld_wait_clr", bus.dp_clr, 1);
      end
      bus.kcfg_valid = 1'b1;
      bus.kcfg_w     = wts;
      @(posedge clk); #1;
      bus.kcfg_valid = 1'b0;
      bus.kcfg_w     = '0;
      chk("st_sready", bus.s_ready, 1);
      chk("st_kload", bus.dp_kload, 1);
      chk("st_dp_w", bus.dp_w, wts);
      chk("st_clr", bus.dp_clr, 0);
      chk("st_kready", bus.kcfg_ready, 0);
      for (int k = 1; k <= 16; k++) begin
         bus.s_valid = (k != gap_pix);
         bus.s_data  = DW'(k);
         bus.start   = (k == start_pix);
         #1;
         chk("dp_pixel", bus.dp_pixel, (k == gap_pix) ? 0 : k);
         @(posedge clk); #1;
         if (k == abort_after) begin
            bus.s_valid = 1'b0;
            bus.start   = 1'b0;
            rst = 1'b1;
            #1;
            chk("abort_outs_zero", outs(), 0);
            return;
         end
      end
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.start   = 1'b0;
      gap = 0;
      while (!bus.frame_done && gap < 10) begin
         gap++;
         @(posedge clk); #1;
      end
      chk("drain_cycles", gap, 2);
      chk("done_busy", bus.busy, 1);
      chk("done_sb_empty", sb.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks         = 0;
      failures       = 0;
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.kcfg_valid = 1'b0;
      bus.kcfg_w     = '0;
      bus.s_valid    = 1'b0;
      bus.s_data     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", outs(), 0);
      rst = 1'b0;

      push_frame(0, 9, 1, 1); run_frame(0, 0, 0, 0, 32'h01010101);
      // back-to-back with a stalled kernel config
      push_frame(0, 9, 1, 1); run_frame(5, 0, 0, 0, 32'h01010101);
      // pixel 6 missing
      push_frame(1, 9, 1, 1); run_frame(0, 6, 0, 0, 32'h01010101);
      chk("err_gap_sticky", bus.err_gap, 1);
      // stray start mid-stream, doubled weights
      push_frame(0, 9, 1, 2); run_frame(0, 0, 8, 0, 32'h02020202);
      // reset after pixel 10
      push_frame(0, 3, 0, 1); run_frame(0, 0, 0, 10, 32'h01010101);
      chk("abort_sb_drained", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_hold_outs", outs(), 0);
      rst = 1'b0;
      push_frame(0, 9, 1, 1); run_frame(0, 0, 0, 0, 32'h01010101);

      repeat (4) @(posedge clk);
      #1;
      chk("final_sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
